// File: rtl/bk_multiword_seq.sv
// ---------------------------------------------------------------------------
// bk_multiword_seq
//
// Purpose:
//   Multi-word adder that time-shares a single 16-bit Brent-Kung adder across
//   WORDS little-endian 16-bit words. One word is processed per clock cycle,
//   with the carry chained through a register between words. A request is
//   accepted in IDLE, processed for WORDS cycles in RUN, and the result is
//   held in DONE until the consumer takes it.
//
// Configuration:
//   BK_SEQ_SUB_EN - when defined, adds the 'sub' input. With sub=1 the block
//                   computes op_a - op_b (op_b words inverted, word-0 carry
//                   forced to 1, cin ignored); cout=1 then means no borrow.
//                   When undefined the block is add-only and 'sub' is absent.
//
// Parameters:
//   WORDS     - number of 16-bit words per operand (2..8), default 4
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - request offers operands
//   in_ready  - block accepts a request this cycle (state == IDLE)
//   op_a      - operand A, 16*WORDS bits, little-endian words
//   op_b      - operand B, 16*WORDS bits, little-endian words
//   cin       - carry into word 0
//   sub       - (BK_SEQ_SUB_EN only) subtract op_b from op_a
//   out_valid - result held and valid (state == DONE)
//   out_ready - consumer takes the result
//   result    - sum, 16*WORDS bits
//   cout      - carry out of the top word
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// brent_kung16bit
//
// Purpose:
//   Combinational 16-bit Brent-Kung parallel-prefix adder with carry-in.
//
// Ports:
//   a, b  - 16-bit addends
//   cin   - carry in
//   sum   - 16-bit sum
//   cout  - carry out of bit 15
// ---------------------------------------------------------------------------
module brent_kung16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g_bit;
  logic [15:0] p_bit;
  logic [15:0] g_pre;
  logic [15:0] p_pre;

  // Prefix tree computed in place. The carry-in is folded into the bit-0
  // generate so that after the tree g_pre[i] is the carry out of bit i.
  // Within each level the positions read are never the positions written,
  // so blocking in-place updates are equivalent to a separate array per level.
  always_comb begin
    g_bit = a & b;
    p_bit = a ^ b;
    g_pre = g_bit;
    p_pre = p_bit;
    g_pre[0] = g_bit[0] | (p_bit[0] & cin);

    // Up-sweep: spans of 2, 4, 8, 16 ending at positions 1,3,..; 3,7,..; 7,15; 15
    for (int i = 1; i < 16; i += 2) begin
      g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i-1]);
      p_pre[i] = p_pre[i] & p_pre[i-1];
    end
    for (int i = 3; i < 16; i += 4) begin
      g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i-2]);
      p_pre[i] = p_pre[i] & p_pre[i-2];
    end
    for (int i = 7; i < 16; i += 8) begin
      g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i-4]);
      p_pre[i] = p_pre[i] & p_pre[i-4];
    end
    g_pre[15] = g_pre[15] | (p_pre[15] & g_pre[7]);

    // Down-sweep: fill in the remaining prefixes from bit 0. Only the
    // generate term matters here because the lower span already reaches bit 0.
    g_pre[11] = g_pre[11] | (p_pre[11] & g_pre[7]);
    for (int i = 5; i < 16; i += 4) begin
      g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i-2]);
    end
    for (int i = 2; i < 16; i += 2) begin
      g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i-1]);
    end
  end

  // Carry into bit i is the prefix generate of bits i-1..0 (cin for bit 0).
  assign sum  = p_bit ^ {g_pre[14:0], cin};
  assign cout = g_pre[15];

endmodule

module bk_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] op_a,
  input  logic [16*WORDS-1:0] op_b,
  input  logic                cin,
`ifdef BK_SEQ_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] result,
  output logic                cout
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [IDX_W-1:0]    idx;
  logic                carry;
  logic [16*WORDS-1:0] a_reg;
  logic [16*WORDS-1:0] b_reg;
`ifdef BK_SEQ_SUB_EN
  logic                sub_reg;
`endif

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_cout;
  logic        accept;
  logic        last_word;

  assign accept    = (state == IDLE) && in_valid;
  assign last_word = (idx == LAST_IDX);

  // Word selection for the shared adder. idx never exceeds WORDS-1, so the
  // part-select always stays inside the operand registers.
  assign add_a = a_reg[16*idx +: 16];
`ifdef BK_SEQ_SUB_EN
  assign add_b = sub_reg ? ~b_reg[16*idx +: 16] : b_reg[16*idx +: 16];
`else
  assign add_b = b_reg[16*idx +: 16];
`endif

  brent_kung16bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. DONE always returns to IDLE before a
  // new request can be taken, so there is no bypass from DONE into RUN.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (last_word) begin
          next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand capture and word-serial datapath. Operands are sampled only on
  // the accepting edge, so input changes during RUN/DONE have no effect.
  // For subtraction the word-0 carry is forced to 1 to complete the two's
  // complement of op_b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      result  <= '0;
      cout    <= 1'b0;
`ifdef BK_SEQ_SUB_EN
      sub_reg <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_reg <= op_a;
        b_reg <= op_b;
        idx   <= '0;
`ifdef BK_SEQ_SUB_EN
        sub_reg <= sub;
        carry   <= sub ? 1'b1 : cin;
`else
        carry <= cin;
`endif
      end else if (state == RUN) begin
        result[16*idx +: 16] <= add_sum;
        carry                <= add_cout;
        if (last_word) begin
          cout <= add_cout;
          idx  <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
